tx_fifo_drain_ctrl: RTL and testbench
=====================================

# tx_fifo_drain_ctrl

Sequences the 32-bit transmit FIFO. On the write side it gates CPU writes against the FIFO's almost-full flag and its post-reset settling window. On the read side it pops words from the synchronous, non-first-word-fall-through FIFO with a fixed read latency and serializes each word into four bytes. Those bytes go to the UART transmitter over a valid/ready handshake. It sits between the core's store path, the FIFO and the UART TX.

## Interface
- `READ_LATENCY`, default 2: cycles from the `fifo_re` cycle until `fifo_dout` is valid (output register enabled).
- `INIT_CYCLES`, default 8: cycles after reset release during which the FIFO must not be read or written.
- `LSB_FIRST`, default 1: 1 sends byte 0 as `[7:0]` first; 0 sends `[31:24]` first.
- `clk` in 1: single clock for the block, the FIFO and the UART TX.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: drain enable; when low, no new pop starts and the current word still completes.
- `cpu_we` in 1: CPU write request.
- `cpu_din` in 32: CPU write data.
- `cpu_stall` out 1: CPU must hold its write.
- `fifo_we` out 1: FIFO write enable.
- `fifo_din` out 32: FIFO write data, always equal to `cpu_din`.
- `fifo_almost_full` in 1: FIFO almost-full flag.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_re` out 1: FIFO read enable.
- `fifo_dout` in 32: FIFO read data.
- `tx_data` out 8: byte to the UART.
- `tx_valid` out 1: byte valid.
- `tx_ready` in 1: UART accepts the byte.
- `init_done` out 1: settling window elapsed.
- `busy` out 1: high in any state other than IDLE.
- `words_sent` out 16: count of fully transmitted words, wraps modulo 2^16.

## Operation
- **Reset values:** `fifo_re`=0, `fifo_we`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `init_done`=0, `words_sent`=0, `cpu_stall`=1, state=INIT, init counter=0.
- **INIT:** count INIT_CYCLES clock edges after reset release, then set `init_done`=1 and enter IDLE. `init_done` never drops again except on reset.
- **Write gating (combinational):**
  - `cpu_stall` = ~`init_done` | `fifo_almost_full`.
  - `fifo_we` = `cpu_we` & ~`cpu_stall`.
  - A write and a pop in the same cycle are legal.
- **IDLE:** if `en` & ~`fifo_empty`, go to REQ; otherwise stay.
- **REQ:** drive `fifo_re`=1 for exactly this one cycle, then go to WAIT with the latency counter at 0.
- **WAIT:** count READ_LATENCY cycles. On the cycle in which `fifo_dout` is valid, latch it into the word register, set byte index=0 and go to SEND.
- **SEND:**
  - `tx_valid`=1 and `tx_data` = selected byte of the word register.
  - `tx_data` stays stable while `tx_valid` & ~`tx_ready`.
  - On `tx_valid` & `tx_ready`, increment the byte index.
  - After byte index 3 transfers, increment `words_sent` and go to REQ if `en` & ~`fifo_empty`, else IDLE.
- **Byte selection:**
  - With LSB_FIRST=1, index k selects `[8k+7:8k]`.
  - With LSB_FIRST=0, index k selects `[31-8k:24-8k]`.
- **`en` deasserted mid-word:** the current word finishes all four bytes, then the block returns to IDLE. `en` has no effect in REQ or WAIT.
- **Empty guard:** `fifo_re` is never asserted while `fifo_empty`=1 or `init_done`=0. The FIFO's RDERR must therefore never fire.
- **Reset mid-operation:** the in-flight word is discarded, all outputs take their reset values immediately (asynchronously), and INIT repeats.

## Timing
- `fifo_re` high in cycle N means the word is latched at the end of cycle N+READ_LATENCY. `tx_valid` rises in cycle N+READ_LATENCY+1.
- IDLE detecting non-empty in cycle M puts `fifo_re` high in cycle M+1.
- With `tx_ready` held high, one word occupies 1 (REQ) + READ_LATENCY (WAIT) + 4 (SEND) cycles, i.e. 7 for back-to-back words at the default latency.
- `words_sent` updates on the clock edge of the final byte handshake.
- `tx_ready` may be high before `tx_valid`; a transfer occurs only when both are high on a clock edge.
- `fifo_empty` is sampled only in IDLE and on the final byte handshake. The FIFO's empty flag lags its write by the primitive's own latency; the block tolerates this by re-checking each word.

## Test plan
- **Reset/init:** release `rst` and hold `cpu_we`=1 → `cpu_stall`=1 and `fifo_we`=0 for 8 cycles, then `init_done`=1, `cpu_stall`=0 and `fifo_we`=1.
- **Single word:** write 32'h44332211, `tx_ready`=1 → `fifo_re` pulses once, `tx_data` sequence 11,22,33,44 starts 3 cycles after `fifo_re`, `words_sent`=1, `busy` returns to 0.
- **Backpressure:** `tx_ready` low for 5 cycles while byte 22 is presented → `tx_data` holds 22 with `tx_valid`=1, no byte is lost or duplicated, and the order is unchanged.
- **Back-to-back with MSB first:** with LSB_FIRST=0, write 3 words (A1B2C3D4, ...) → 12 bytes in MSB-first order, 7-cycle word period, no `fifo_re` while `fifo_empty`=1, `words_sent`=3.
- **Flow control:** drive `fifo_almost_full`=1 with `cpu_we`=1 → `cpu_stall`=1 and `fifo_we`=0 on the same cycle. Drop `en` mid-word → the remaining bytes finish and no further `fifo_re` is issued.
- **Reset mid-SEND:** assert `rst` after byte 2 of a word → `tx_valid`=0 and `busy`=0 immediately, `words_sent`=0, INIT repeats.

Source files
------------

// File: rtl/tx_fifo_drain_ctrl.sv
// Transmit FIFO sequencer: gates CPU writes during settling/almost-full and
// drains 32-bit words from a fixed-latency FIFO as four bytes over valid/ready.
module tx_fifo_drain_ctrl #(
    parameter int READ_LATENCY = 2,
    parameter int INIT_CYCLES  = 8,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cpu_we,
    input  logic [31:0] cpu_din,
    output logic        cpu_stall,
    output logic        fifo_we,
    output logic [31:0] fifo_din,
    input  logic        fifo_almost_full,
    input  logic        fifo_empty,
    output logic        fifo_re,
    input  logic [31:0] fifo_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        init_done,
    output logic        busy,
    output logic [15:0] words_sent
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   initCnt_q;
    logic [LW-1:0]   lat_q;
    logic [1:0]      byteIdx_q;
    logic [31:0]     word_q;
    logic            fifoRe_q;
    logic            txValid_q;
    logic [7:0]      txData_q;
    logic            busy_q;
    logic            initDone_q;
    logic [15:0]     wordsSent_q;
    logic            popNext;

    function automatic logic [7:0] selByte(input logic [31:0] w, input logic [1:0] k);
        logic [4:0] sh;
        sh = LSB_FIRST ? {k, 3'b000} : 5'(5'd24 - {k, 3'b000});
        return 8'(w >> sh);
    endfunction

    // The empty flag is only trusted at decision points, so each new word is re-qualified here.
    assign popNext   = en & ~fifo_empty;

    assign cpu_stall = ~initDone_q | fifo_almost_full;
    assign fifo_we   = cpu_we & ~cpu_stall;
    assign fifo_din  = cpu_din;

    assign fifo_re    = fifoRe_q;
    assign tx_valid   = txValid_q;
    assign tx_data    = txData_q;
    assign busy       = busy_q;
    assign init_done  = initDone_q;
    assign words_sent = wordsSent_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            initCnt_q   <= '0;
            lat_q       <= '0;
            byteIdx_q   <= '0;
            word_q      <= '0;
            fifoRe_q    <= 1'b0;
            txValid_q   <= 1'b0;
            txData_q    <= '0;
            busy_q      <= 1'b0;
            initDone_q  <= 1'b0;
            wordsSent_q <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (initCnt_q == INIT_LAST) begin
                        initDone_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        initCnt_q <= initCnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (popNext) begin
                        state_q  <= S_REQ;
                        fifoRe_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    fifoRe_q <= 1'b0;
                    lat_q    <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // The last wait cycle is the one where fifo_dout carries the popped word.
                    if (lat_q == LAT_LAST) begin
                        word_q    <= fifo_dout;
                        byteIdx_q <= '0;
                        txValid_q <= 1'b1;
                        txData_q  <= selByte(fifo_dout, 2'd0);
                        state_q   <= S_SEND;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (byteIdx_q == 2'd3) begin
                            txValid_q   <= 1'b0;
                            wordsSent_q <= wordsSent_q + 16'd1;
                            if (popNext) begin
                                state_q  <= S_REQ;
                                fifoRe_q <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            byteIdx_q <= byteIdx_q + 2'd1;
                            txData_q  <= selByte(word_q, byteIdx_q + 2'd1);
                        end
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_fifo_drain_ctrl.sv
// Bench for tx_fifo_drain_ctrl: LSB-first and MSB-first instances share one
// behavioural FIFO; directed timing steps plus a random phase checked by a scoreboard.
module tb_tx_fifo_drain_ctrl;

    localparam int READ_LATENCY = 2;
    localparam int INIT_CYCLES  = 8;
    localparam int AF_LEVEL     = 12;
    localparam int DEPTH        = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cpuWe = 1'b0;
    logic [31:0] cpuDin = '0;
    logic        txReady = 1'b0;
    logic        forceAf = 1'b0;
    logic        fifoAfModel = 1'b0;
    logic        fifoEmpty = 1'b1;
    logic [31:0] rdStage1 = '0;
    logic [31:0] rdStage2 = '0;
    logic        fifoAf;

    logic        cpuStallL, fifoWeL, fifoReL, txValidL, initDoneL, busyL;
    logic [31:0] fifoDinL;
    logic [7:0]  txDataL;
    logic [15:0] wordsSentL;
    logic        cpuStallM, fifoWeM, fifoReM, txValidM, initDoneM, busyM;
    logic [31:0] fifoDinM;
    logic [7:0]  txDataM;
    logic [15:0] wordsSentM;

    int          assertCount = 0;
    int          failCount = 0;
    logic [31:0] fifoQ[$];
    logic [31:0] expWords[$];
    logic [7:0]  rxL[$];
    logic [7:0]  rxM[$];
    int          reCount = 0;
    int          emptyErr = 0;
    int          holdErrL = 0;
    int          holdErrM = 0;
    int          ovfErr = 0;
    logic        prevStallL = 1'b0;
    logic        prevStallM = 1'b0;
    logic [7:0]  prevDataL = '0;
    logic [7:0]  prevDataM = '0;
    logic [31:0] popped;
    logic [31:0] b2bWords[3] = '{32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};

    assign fifoAf = fifoAfModel | forceAf;

    always #5 clk = ~clk;

    tx_fifo_drain_ctrl #(.READ_LATENCY(READ_LATENCY), .INIT_CYCLES(INIT_CYCLES), .LSB_FIRST(1'b1)) dutLsb (
        .clk(clk), .rst(rst), .en(en), .cpu_we(cpuWe), .cpu_din(cpuDin),
        .cpu_stall(cpuStallL), .fifo_we(fifoWeL), .fifo_din(fifoDinL),
        .fifo_almost_full(fifoAf), .fifo_empty(fifoEmpty), .fifo_re(fifoReL),
        .fifo_dout(rdStage2), .tx_data(txDataL), .tx_valid(txValidL), .tx_ready(txReady),
        .init_done(initDoneL), .busy(busyL), .words_sent(wordsSentL)
    );

    tx_fifo_drain_ctrl #(.READ_LATENCY(READ_LATENCY), .INIT_CYCLES(INIT_CYCLES), .LSB_FIRST(1'b0)) dutMsb (
        .clk(clk), .rst(rst), .en(en), .cpu_we(cpuWe), .cpu_din(cpuDin),
        .cpu_stall(cpuStallM), .fifo_we(fifoWeM), .fifo_din(fifoDinM),
        .fifo_almost_full(fifoAf), .fifo_empty(fifoEmpty), .fifo_re(fifoReM),
        .fifo_dout(rdStage2), .tx_data(txDataM), .tx_valid(txValidM), .tx_ready(txReady),
        .init_done(initDoneM), .busy(busyM), .words_sent(wordsSentM)
    );

    // Behavioural FIFO: two output register stages, junk on the bus when nothing was read.
    always @(posedge clk) begin
        popped = $urandom;
        if (fifoReL && fifoQ.size() > 0) popped = fifoQ.pop_front();
        if (fifoWeL) begin
            fifoQ.push_back(cpuDin);
            expWords.push_back(cpuDin);
        end
        if (fifoQ.size() > DEPTH) ovfErr++;
        rdStage1    <= popped;
        rdStage2    <= rdStage1;
        fifoEmpty   <= (fifoQ.size() == 0);
        fifoAfModel <= (fifoQ.size() >= AF_LEVEL);
    end

    // Handshake capture, hold-under-backpressure and empty-read monitors.
    always @(posedge clk) begin
        if (!rst) begin
            if (txValidL && txReady) rxL.push_back(txDataL);
            if (txValidM && txReady) rxM.push_back(txDataM);
            if (prevStallL && (!txValidL || txDataL !== prevDataL)) holdErrL++;
            if (prevStallM && (!txValidM || txDataM !== prevDataM)) holdErrM++;
            if (fifoReL) reCount++;
            if ((fifoReL || fifoReM) && fifoEmpty) emptyErr++;
        end
        prevStallL = !rst && txValidL && !txReady;
        prevStallM = !rst && txValidM && !txReady;
        prevDataL  = txDataL;
        prevDataM  = txDataM;
    end

    function automatic logic [7:0] expByte(input logic [31:0] w, input int k, input bit lsbFirst);
        int sh;
        sh = lsbFirst ? 8 * k : 24 - 8 * k;
        return 8'((w >> sh) & 32'hFF);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] din);
        @(negedge clk);
        cpuWe  = we;
        cpuDin = din;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int reBefore;
        int errs;
        int base;
        int reCycles[$];
        logic expWe;

        en = 1'b1; txReady = 1'b1; cpuWe = 1'b1; cpuDin = 32'h44332211;
        repeat (3) @(negedge clk);
        checkOutput("reset fifo_re", 32'(fifoReL), 32'd0);
        checkOutput("reset fifo_we", 32'(fifoWeL), 32'd0);
        checkOutput("reset tx_valid", 32'(txValidL), 32'd0);
        checkOutput("reset tx_data", 32'(txDataL), 32'd0);
        checkOutput("reset busy", 32'(busyL), 32'd0);
        checkOutput("reset init_done", 32'(initDoneL), 32'd0);
        checkOutput("reset words_sent", 32'(wordsSentL), 32'd0);
        checkOutput("reset cpu_stall", 32'(cpuStallL), 32'd1);

        // Settling window with a write held pending.
        rst = 1'b0;
        for (int i = 0; i < INIT_CYCLES; i++) begin
            #1;
            checkOutput("init cpu_stall", 32'(cpuStallL), 32'd1);
            checkOutput("init fifo_we", 32'(fifoWeL), 32'd0);
            checkOutput("init fifo_re", 32'(fifoReL), 32'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("init_done after window", 32'(initDoneL), 32'd1);
        checkOutput("stall after window", 32'(cpuStallL), 32'd0);
        checkOutput("fifo_we after window", 32'(fifoWeL), 32'd1);
        checkOutput("fifo_din follows cpu_din", fifoDinL, 32'h44332211);

        // Single word, ready held high.
        applyStimulus(1'b0, 32'h0);
        waited = 0;
        while (!fifoReL && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("single empty-to-re latency", 32'(waited), 32'd1);
        checkOutput("single busy during pop", 32'(busyL), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("single fifo_re one pulse", 32'(fifoReL), 32'd0);
            checkOutput("single tx_valid timing", 32'(txValidL), 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) begin
                checkOutput("single byte lsb", 32'(txDataL), 32'(expByte(32'h44332211, k - 3, 1'b1)));
                checkOutput("single byte msb", 32'(txDataM), 32'(expByte(32'h44332211, k - 3, 1'b0)));
            end
        end
        checkOutput("single words_sent", 32'(wordsSentL), 32'd1);
        checkOutput("single busy released", 32'(busyL), 32'd0);

        // Backpressure while byte 22 is presented.
        applyStimulus(1'b1, 32'h44332211);
        applyStimulus(1'b0, 32'h0);
        waited = 0;
        while (!(txValidL && txDataL == 8'h22) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp reached byte 22", 32'(waited < 30), 32'd1);
        txReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp tx_valid held", 32'(txValidL), 32'd1);
            checkOutput("bp tx_data held", 32'(txDataL), 32'h22);
        end
        txReady = 1'b1;
        waited = 0;
        while (busyL && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("bp drained", 32'(waited < 30), 32'd1);
        checkOutput("bp byte count", 32'(rxL.size()), 32'd8);
        errs = 0;
        for (int k = 0; k < 4 && rxL.size() >= 8; k++)
            if (rxL[4 + k] !== expByte(32'h44332211, k, 1'b1)) errs++;
        checkOutput("bp byte order", 32'(errs), 32'd0);
        checkOutput("bp words_sent", 32'(wordsSentL), 32'd2);

        // Three queued words drained back to back.
        en = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, b2bWords[i]);
        applyStimulus(1'b0, 32'h0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fifoReL) reCycles.push_back(c);
        end
        checkOutput("b2b pop count", 32'(reCycles.size()), 32'd3);
        if (reCycles.size() == 3) begin
            checkOutput("b2b word period 1", 32'(reCycles[1] - reCycles[0]), 32'd7);
            checkOutput("b2b word period 2", 32'(reCycles[2] - reCycles[1]), 32'd7);
        end
        checkOutput("b2b msb byte count", 32'(rxM.size()), 32'd20);
        errs = 0;
        base = rxM.size() - 12;
        for (int i = 0; i < 3 && base >= 0; i++)
            for (int k = 0; k < 4; k++)
                if (rxM[base + 4 * i + k] !== expByte(b2bWords[i], k, 1'b0)) errs++;
        checkOutput("b2b msb byte order", 32'(errs), 32'd0);
        checkOutput("b2b words_sent msb", 32'(wordsSentM), 32'd5);

        // Almost-full stalls a write in the same cycle.
        @(negedge clk);
        forceAf = 1'b1; cpuWe = 1'b1; cpuDin = 32'hDEAD0001;
        #1;
        checkOutput("af cpu_stall", 32'(cpuStallL), 32'd1);
        checkOutput("af fifo_we lsb", 32'(fifoWeL), 32'd0);
        checkOutput("af fifo_we msb", 32'(fifoWeM), 32'd0);
        checkOutput("af fifo_din", fifoDinM, 32'hDEAD0001);
        #1;
        cpuWe = 1'b0; forceAf = 1'b0;

        // Enable dropped mid-word: that word completes, the next one stays queued.
        reBefore = reCount;
        applyStimulus(1'b1, 32'h0A0B0C0D);
        applyStimulus(1'b1, 32'h1A1B1C1D);
        applyStimulus(1'b0, 32'h0);
        waited = 0;
        while (!txValidL && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("en-drop reached send", 32'(waited < 30), 32'd1);
        en = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("en-drop single pop", 32'(reCount - reBefore), 32'd1);
        checkOutput("en-drop words_sent", 32'(wordsSentL), 32'd6);
        checkOutput("en-drop busy", 32'(busyL), 32'd0);
        checkOutput("en-drop word left queued", 32'(fifoQ.size()), 32'd1);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            cpuWe   = ($urandom_range(0, 99) < 45);
            cpuDin  = $urandom;
            txReady = ($urandom_range(0, 99) < 70);
            forceAf = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            #1;
            expWe = cpuWe && !(fifoAfModel || forceAf);
            checkOutput("rand fifo_we lsb", 32'(fifoWeL), 32'(expWe));
            checkOutput("rand fifo_we msb", 32'(fifoWeM), 32'(expWe));
        end
        @(negedge clk);
        cpuWe = 1'b0; forceAf = 1'b0; en = 1'b1; txReady = 1'b1;
        waited = 0;
        while ((fifoQ.size() != 0 || busyL || busyM) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rand drain finished", 32'(waited < 1000), 32'd1);
        checkOutput("sb lsb byte count", 32'(rxL.size()), 32'(expWords.size() * 4));
        checkOutput("sb msb byte count", 32'(rxM.size()), 32'(expWords.size() * 4));
        errs = 0;
        for (int i = 0; i < expWords.size(); i++)
            for (int k = 0; k < 4; k++) begin
                if (4 * i + k < rxL.size() && rxL[4 * i + k] !== expByte(expWords[i], k, 1'b1)) errs++;
                if (4 * i + k < rxM.size() && rxM[4 * i + k] !== expByte(expWords[i], k, 1'b0)) errs++;
            end
        checkOutput("sb byte contents", 32'(errs), 32'd0);
        checkOutput("sb words_sent lsb", 32'(wordsSentL), 32'(16'(expWords.size())));
        checkOutput("sb words_sent msb", 32'(wordsSentM), 32'(16'(expWords.size())));
        checkOutput("sb hold violations lsb", 32'(holdErrL), 32'd0);
        checkOutput("sb hold violations msb", 32'(holdErrM), 32'd0);
        checkOutput("sb read while empty", 32'(emptyErr), 32'd0);
        checkOutput("sb fifo overflow", 32'(ovfErr), 32'd0);

        // Reset while the third byte of a word is presented.
        applyStimulus(1'b1, 32'h31323334);
        applyStimulus(1'b0, 32'h0);
        waited = 0;
        while (!(txValidL && txDataL == 8'h32) && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst reached byte 2", 32'(waited < 30), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst tx_valid", 32'(txValidL), 32'd0);
        checkOutput("rst busy", 32'(busyL), 32'd0);
        checkOutput("rst words_sent", 32'(wordsSentL), 32'd0);
        checkOutput("rst init_done", 32'(initDoneL), 32'd0);
        checkOutput("rst cpu_stall", 32'(cpuStallL), 32'd1);
        checkOutput("rst msb tx_valid", 32'(txValidM), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < INIT_CYCLES; i++) begin
            #1;
            checkOutput("re-init init_done", 32'(initDoneL), 32'd0);
            checkOutput("re-init fifo_re", 32'(fifoReL), 32'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("re-init done lsb", 32'(initDoneL), 32'd1);
        checkOutput("re-init done msb", 32'(initDoneM), 32'd1);
        checkOutput("re-init words_sent", 32'(wordsSentM), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
